mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_div_step.sv | 21 ++
 rtl/mdu_ctrl.sv | 156 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and iteration count.
// Optional single-cycle multiplier is selected with macro MDU_FAST_MULT_EN.
package mdu_pkg;

    localparam int MDU_ITERS = 32;

    typedef enum logic [2:0] {
        OP_CLR,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } mult_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_t;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor, and keep the difference only when it did not go negative.
module mdu_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // 33 bits: the shifted remainder can exceed 2^32 before the subtract brings it back under.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    assign o_rem = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign o_quo = {i_quo[30:0], ~w_diff[32]};

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit: iterative shift-add multiplier and restoring divider on magnitudes,
// signs fixed up in a final cycle. Define MDU_FAST_MULT_EN for a single-cycle multiply.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter logic [31:0] RESET_HILO = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  mult_t       op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  r_state;
    mdu_state_t  w_next;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_op_div;
    logic        w_op_signed;
    logic        w_last;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign w_op_signed = (op == OP_DIV) || (op == OP_MULT);
    assign w_accept    = (r_state == IDLE) && start && !flush && (op != OP_CLR);
    assign w_last      = (r_cnt == 5'(MDU_ITERS - 1));

    // Accumulator holds {remainder, quotient} while dividing and {partial product, multiplier} while multiplying.
    mdu_div_step u_div_step (
        .i_rem     (r_acc[63:32]),
        .i_quo     (r_acc[31:0]),
        .i_divisor (r_b),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

`ifndef MDU_FAST_MULT_EN
    logic [32:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
`endif

    assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_op_div ? DIV : MUL;
`ifdef MDU_FAST_MULT_EN
            MUL:  w_next = FIX;
`else
            MUL:  if (w_last) w_next = FIX;
`endif
            DIV:  if (w_last) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush && (r_state != IDLE)) w_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= 64'd0;
            r_b       <= 32'd0;
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= RESET_HILO;
            r_lo      <= RESET_HILO;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_accept) begin
                        r_acc     <= {32'd0, w_op_signed ? abs32(a) : a};
                        r_b       <= w_op_signed ? abs32(b) : b;
                        r_cnt     <= 5'd0;
                        r_is_div  <= w_op_div;
                        r_neg_res <= w_op_signed && (a[31] ^ b[31]);
                        r_neg_rem <= w_op_signed && a[31];
                    end
                end
                MUL: begin
`ifdef MDU_FAST_MULT_EN
                    r_acc <= {32'd0, r_acc[31:0]} * {32'd0, r_b};
`else
                    r_acc <= {w_mul_sum, r_acc[31:1]};
                    r_cnt <= r_cnt + 5'd1;
`endif
                end
                DIV: begin
                    r_acc <= {w_rem_nxt, w_quo_nxt};
                    r_cnt <= r_cnt + 5'd1;
                end
                FIX: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            // Divide-by-zero: the restoring loop already leaves |a| as remainder; force the quotient.
                            r_lo <= (r_b == 32'd0) ? 32'hFFFF_FFFF : w_quo;
                            r_hi <= w_rem;
                        end else begin
                            r_lo <= w_prod[31:0];
                            r_hi <= w_prod[63:32];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for results and latency, plus hand sequences
// for flush, mid-operation reset, ignored requests and MTHI/MTLO interplay.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam logic [31:0] RST_VAL = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    mult_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mdu_ctrl #(.RESET_HILO(RST_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        mult_t       op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input mult_t o);
`ifdef MDU_FAST_MULT_EN
        return ((o == OP_MULT) || (o == OP_MULTU)) ? 3 : 34;
`else
        return (o == OP_MULT) ? 34 : 34;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Drive start for one cycle; returns in cycle T+1 with cyc = 1.
    task automatic issue(input mult_t o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy after accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input string name, input int lat, input logic [31:0] ehi, input logic [31:0] elo);
        while (done !== 1'b1 && cyc < 100) step();
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({name, " lo"}, {32'd0, lo}, {32'd0, elo});
        check({name, " idle at done"}, {63'd0, busy}, 64'd0);
        step();
        check({name, " done pulse width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hb;
        logic [31:0] lb;
        int          n_done;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 32'hA3D7_0A38};
        vecs[6]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{OP_MULT,  32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1};

        reset = 1'b1; start = 1'b0; op = OP_CLR; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset hi", {32'd0, hi}, {32'd0, RST_VAL});
        check("reset lo", {32'd0, lo}, {32'd0, RST_VAL});
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);

        // start with CLR is ignored
        start = 1'b1; op = OP_CLR; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("clr ignored busy", {63'd0, busy}, 64'd0);

        // flush overrides start in IDLE
        start = 1'b1; flush = 1'b1; op = OP_MULTU;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush blocks start", {63'd0, busy}, 64'd0);

        // direct MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555_0002;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h0000_0000_AAAA_0001);
        check("mtlo", {32'd0, lo}, 64'h0000_0000_5555_0002);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), exp_lat(vecs[i].op), vecs[i].hi, vecs[i].lo);
        end

        // direct write and accept in the same IDLE cycle
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; cyc = 1;
        check("idle write+accept hi", {32'd0, hi}, 64'h0000_0000_0BAD_F00D);
        check("idle write+accept busy", {63'd0, busy}, 64'd1);
        wait_done("write+accept", 34, 32'h0000_0002, 32'h0000_000E);

        // writes and start while busy are ignored
        issue(OP_DIVU, 32'd100, 32'd7);
        hb = hi; lb = lo;
        step(); step();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
        step();
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        check("hi_we while busy", {32'd0, hi}, {32'd0, hb});
        check("lo_we while busy", {32'd0, lo}, {32'd0, lb});
        wait_done("start while busy", 34, 32'h0000_0002, 32'h0000_000E);

        // flush at iteration 10
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        hb = hi; lb = lo;
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        while (cyc < 11) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy next cycle", {63'd0, busy}, 64'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) n_done++;
            step();
        end
        check("flush no done", 64'(n_done), 64'd0);
        check("flush hi kept", {32'd0, hi}, {32'd0, hb});
        check("flush lo kept", {32'd0, lo}, {32'd0, lb});
        issue(OP_MULT, 32'h0000_0005, 32'hFFFF_FFFD);
        wait_done("after flush", exp_lat(OP_MULT), 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // asynchronous reset at iteration 20
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        while (cyc < 21) step();
        #2 reset = 1'b1;
        #1;
        check("midop reset hi", {32'd0, hi}, {32'd0, RST_VAL});
        check("midop reset lo", {32'd0, lo}, {32'd0, RST_VAL});
        check("midop reset busy", {63'd0, busy}, 64'd0);
        check("midop reset done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            @(negedge clk);
        end
        check("stays idle after reset", 64'(n_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
